puf_crp_controller: RTL and testbench

//  Parametrised challenge-response sequencer placed between a UART byte link and an arbiter PUF.
//  - Assembles CHAL_BYTES received bytes into a challenge and applies it to the PUF.
//  - Runs a two-phase settle/fire evaluation.
//  - Captures the response and streams it back as RESP_BYTES bytes.

---
 rtl/puf_crp_controller.sv | 199 +++++++++++++++++++
 tb/tb_puf_crp_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_crp_controller.sv
// puf_crp_controller: challenge-response sequencer between a UART byte link and an arbiter PUF.
// The controller collects challenge bytes and drives the PUF through a settle phase and a fire phase.
// It then captures the response and streams it back one byte at a time.
// Optional feature macro: PUF_CRP_ECHO_EN. When it is defined, the challenge bytes are echoed
// MSB first ahead of the response bytes.
module puf_crp_controller #(
    parameter int CHAL_BYTES    = 8,
    parameter int RESP_BYTES    = 8,
    parameter int SETTLE_CYCLES = 65535,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    output logic [7:0]              tx_byte,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [8*CHAL_BYTES-1:0] puf_challenge,
    output logic                    puf_signal,
    input  logic [8*RESP_BYTES-1:0] puf_response,
    output logic                    busy,
    output logic                    done,
    output logic                    rx_drop
);

    localparam int CW   = 8 * CHAL_BYTES;
    localparam int RW   = 8 * RESP_BYTES;
    localparam int BC_W = $clog2((CHAL_BYTES < 2) ? 2 : CHAL_BYTES);
    localparam int OC_W = $clog2((RESP_BYTES < 2) ? 2 : RESP_BYTES);

    localparam logic [BC_W-1:0]  CHAL_LAST   = BC_W'(CHAL_BYTES - 1);
    localparam logic [OC_W-1:0]  RESP_LAST   = OC_W'(RESP_BYTES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [BC_W-1:0]  BC_ONE      = BC_W'(1);
    localparam logic [OC_W-1:0]  OC_ONE      = OC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_RECV,
        S_ARM,
        S_FIRE,
        S_CAPTURE,
        S_SEND
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_chal;
    logic [CW-1:0]     r_puf_challenge;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [CNT_W-1:0]  r_settle;
    logic [RW-1:0]     r_resp_sr;
    logic [OC_W-1:0]   r_out_cnt;
    logic [7:0]        r_tx_byte;
    logic              r_tx_valid;
    logic              r_puf_signal;
    logic              r_busy;
    logic              r_done;
    logic              r_rx_drop;

    logic [CW-1:0]     w_chal_next;
    logic [RW-1:0]     w_resp_next;
    logic              w_tx_fire;

`ifdef PUF_CRP_ECHO_EN
    logic [CW-1:0]     r_echo_sr;
    logic [BC_W-1:0]   r_echo_cnt;
    logic              r_echo_phase;
    logic [CW-1:0]     w_echo_next;
`endif

    // Next-value shifts: the new byte enters at the bottom of the challenge, and the response drains from the bottom
    always_comb begin
        w_chal_next      = r_chal << 8;
        w_chal_next[7:0] = rx_byte;
        w_resp_next      = r_resp_sr >> 8;
`ifdef PUF_CRP_ECHO_EN
        w_echo_next      = r_echo_sr << 8;
`endif
    end

    assign w_tx_fire = r_tx_valid && tx_ready;

    // Main sequencer: receive, arm, fire, capture and send, with every output registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_RECV;
            r_chal          <= '0;
            r_puf_challenge <= '0;
            r_byte_cnt      <= '0;
            r_settle        <= '0;
            r_resp_sr       <= '0;
            r_out_cnt       <= '0;
            r_tx_byte       <= '0;
            r_tx_valid      <= 1'b0;
            r_puf_signal    <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_rx_drop       <= 1'b0;
`ifdef PUF_CRP_ECHO_EN
            r_echo_sr       <= '0;
            r_echo_cnt      <= '0;
            r_echo_phase    <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_rx_drop <= rx_valid && (r_state != S_RECV);
            case (r_state)
                S_RECV: begin
                    if (rx_valid) begin
                        r_chal <= w_chal_next;
                        if (r_byte_cnt == CHAL_LAST) begin
                            r_puf_challenge <= w_chal_next;
                            r_byte_cnt      <= '0;
                            r_puf_signal    <= 1'b0;
                            r_settle        <= '0;
                            r_busy          <= 1'b1;
                            r_state         <= S_ARM;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BC_ONE;
                        end
                    end
                end
                S_ARM: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_puf_signal <= 1'b1;
                        r_settle     <= '0;
                        r_state      <= S_FIRE;
                    end else begin
                        r_settle <= r_settle + CNT_ONE;
                    end
                end
                S_FIRE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= S_CAPTURE;
                    end else begin
                        r_settle <= r_settle + CNT_ONE;
                    end
                end
                S_CAPTURE: begin
                    r_resp_sr  <= puf_response;
                    r_out_cnt  <= RESP_LAST;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
`ifdef PUF_CRP_ECHO_EN
                    r_echo_sr    <= r_puf_challenge;
                    r_echo_cnt   <= CHAL_LAST;
                    r_echo_phase <= 1'b1;
                    r_tx_byte    <= r_puf_challenge[CW-1 -: 8];
`else
                    r_tx_byte    <= puf_response[7:0];
`endif
                end
                S_SEND: begin
                    if (w_tx_fire) begin
`ifdef PUF_CRP_ECHO_EN
                        if (r_echo_phase) begin
                            if (r_echo_cnt == '0) begin
                                r_echo_phase <= 1'b0;
                                r_tx_byte    <= r_resp_sr[7:0];
                            end else begin
                                r_echo_sr  <= w_echo_next;
                                r_tx_byte  <= w_echo_next[CW-1 -: 8];
                                r_echo_cnt <= r_echo_cnt - BC_ONE;
                            end
                        end else
`endif
                        begin
                            if (r_out_cnt == '0) begin
                                r_tx_valid <= 1'b0;
                                r_done     <= 1'b1;
                                r_busy     <= 1'b0;
                                r_state    <= S_RECV;
                            end else begin
                                r_resp_sr <= w_resp_next;
                                r_tx_byte <= w_resp_next[7:0];
                                r_out_cnt <= r_out_cnt - OC_ONE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_RECV;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_byte       = r_tx_byte;
    assign tx_valid      = r_tx_valid;
    assign puf_challenge = r_puf_challenge;
    assign puf_signal    = r_puf_signal;
    assign busy          = r_busy;
    assign done          = r_done;
    assign rx_drop       = r_rx_drop;

endmodule

// File: tb/tb_puf_crp_controller.sv
// tb_puf_crp_controller: directed bench for puf_crp_controller.
// It drives a full-size 8/8 instance and a small 1/2 instance, both with SETTLE_CYCLES=4.
// Define PUF_CRP_ECHO_EN for both the RTL and this bench to exercise the challenge echo.
module tb_puf_crp_controller;

   logic        clk;
   logic        rst_n;

   // main instance (8-byte challenge, 8-byte response)
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic [63:0] puf_challenge;
   logic        puf_signal;
   logic [63:0] puf_response;
   logic        busy;
   logic        done;
   logic        rx_drop;

   // small instance (1-byte challenge, 2-byte response)
   logic        sRxValid;
   logic [7:0]  sRxByte;
   logic [7:0]  sTxByte;
   logic        sTxValid;
   logic        sTxReady;
   logic [7:0]  sChallenge;
   logic        sPufSignal;
   logic [15:0] sResponse;
   logic        sBusy;
   logic        sDone;
   logic        sRxDrop;

   int          errorCount;
   int          checkCount;
   logic [7:0]  expBytes [0:31];
   int          expN;

   puf_crp_controller #(
      .CHAL_BYTES(8), .RESP_BYTES(8), .SETTLE_CYCLES(4), .CNT_W(16)
   ) uMain (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .puf_challenge(puf_challenge), .puf_signal(puf_signal),
      .puf_response(puf_response), .busy(busy), .done(done), .rx_drop(rx_drop)
   );

   puf_crp_controller #(
      .CHAL_BYTES(1), .RESP_BYTES(2), .SETTLE_CYCLES(4), .CNT_W(16)
   ) uSmall (
      .clk(clk), .rst_n(rst_n), .rx_valid(sRxValid), .rx_byte(sRxByte),
      .tx_byte(sTxByte), .tx_valid(sTxValid), .tx_ready(sTxReady),
      .puf_challenge(sChallenge), .puf_signal(sPufSignal),
      .puf_response(sResponse), .busy(sBusy), .done(sDone), .rx_drop(sRxDrop)
   );

   // free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // present one byte to the main instance for exactly one clock, called at a falling edge
   task automatic applyStimulus(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // expected transmit order: optional challenge echo MSB first, then the response LSB first
   task automatic loadExpected(input logic [63:0] chal, input logic [63:0] resp);
      logic [63:0] c;
      logic [63:0] r;
      c    = chal;
      r    = resp;
      expN = 0;
`ifdef PUF_CRP_ECHO_EN
      for (int i = 0; i < 8; i++) begin
         expBytes[expN] = c[63:56];
         c = c << 8;
         expN++;
      end
`endif
      for (int i = 0; i < 8; i++) begin
         expBytes[expN] = r[7:0];
         r = r >> 8;
         expN++;
      end
   endtask

   // drain the main transmitter, optionally toggling tx_ready, and check the done pulse
   task automatic collectBytes(input string tag, input bit toggle);
      int         got;
      int         cyc;
      bit         stalled;
      logic [7:0] heldByte;
      bit         ready;
      got      = 0;
      cyc      = 0;
      stalled  = 0;
      heldByte = '0;
      while (got < expN && cyc < 300) begin
         ready    = toggle ? (cyc % 2 == 0) : 1'b1;
         tx_ready = ready;
         if (stalled) begin
            checkOutput({tag, "_stall_valid"}, 64'(tx_valid), 64'd1);
            checkOutput({tag, "_stall_byte"}, 64'(tx_byte), 64'(heldByte));
         end
         if (tx_valid) begin
            checkOutput({tag, "_done_early"}, 64'(done), 64'd0);
            if (ready) begin
               checkOutput($sformatf("%s_byte%0d", tag, got), 64'(tx_byte), 64'(expBytes[got]));
               got++;
               stalled = 0;
            end else begin
               stalled  = 1;
               heldByte = tx_byte;
            end
         end
         @(negedge clk);
         cyc++;
      end
      tx_ready = 1'b1;
      checkOutput({tag, "_count"}, 64'(got), 64'(expN));
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      checkOutput({tag, "_valid_off"}, 64'(tx_valid), 64'd0);
      checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
      @(negedge clk);
      checkOutput({tag, "_done_once"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [7:0] chalA [0:7];
      logic [7:0] sExp [0:2];
      int         sN;
      int         sGot;
      int         waitCyc;

      chalA = '{8'hE5, 8'hF2, 8'h80, 8'h3E, 8'h30, 8'hE0, 8'hB4, 8'hBC};
      errorCount   = 0;
      checkCount   = 0;
      rst_n        = 1'b0;
      rx_valid     = 1'b0;
      rx_byte      = '0;
      tx_ready     = 1'b1;
      puf_response = 64'h0123456789ABCDEF;
      sRxValid     = 1'b0;
      sRxByte      = '0;
      sTxReady     = 1'b1;
      sResponse    = 16'hBEEF;

      // reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("rst_tx_byte", 64'(tx_byte), 64'd0);
      checkOutput("rst_challenge", puf_challenge, 64'd0);
      checkOutput("rst_signal", 64'(puf_signal), 64'd1);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_drop", 64'(rx_drop), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic run with the response-only or echo sequence
      $display("[TB] basic challenge/response");
      loadExpected(64'hE5F2803E30E0B4BC, 64'h0123456789ABCDEF);
      for (int i = 0; i < 8; i++) applyStimulus(chalA[i]);
      checkOutput("t2_challenge", puf_challenge, 64'hE5F2803E30E0B4BC);
      checkOutput("t2_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("t2_arm_low%0d", i), 64'(puf_signal), 64'd0);
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("t2_fire_high%0d", i), 64'(puf_signal), 64'd1);
         checkOutput($sformatf("t2_fire_novalid%0d", i), 64'(tx_valid), 64'd0);
         @(negedge clk);
      end
      checkOutput("t2_capture_novalid", 64'(tx_valid), 64'd0);
      @(negedge clk);
      checkOutput("t2_latency_valid", 64'(tx_valid), 64'd1);
      collectBytes("t2", 1'b0);

      // byte dropped while arming
      $display("[TB] drop during ARM");
      puf_response = 64'hFEDCBA9876543210;
      loadExpected(64'h1122334455667788, 64'hFEDCBA9876543210);
      for (int i = 0; i < 8; i++) applyStimulus(8'(8'h11 * (i + 1)));
      checkOutput("t4_challenge", puf_challenge, 64'h1122334455667788);
      applyStimulus(8'h55);
      checkOutput("t4_drop_pulse", 64'(rx_drop), 64'd1);
      @(negedge clk);
      checkOutput("t4_drop_clear", 64'(rx_drop), 64'd0);
      checkOutput("t4_challenge_kept", puf_challenge, 64'h1122334455667788);
      collectBytes("t4", 1'b0);

      // backpressure with tx_ready toggling every cycle
      $display("[TB] backpressure");
      puf_response = 64'h0123456789ABCDEF;
      loadExpected(64'hE5F2803E30E0B4BC, 64'h0123456789ABCDEF);
      for (int i = 0; i < 8; i++) applyStimulus(chalA[i]);
      collectBytes("t3", 1'b1);

      // small instance: one challenge byte, two response bytes
      $display("[TB] small parameter set");
      sN = 0;
`ifdef PUF_CRP_ECHO_EN
      sExp[sN] = 8'hA5; sN++;
`endif
      sExp[sN] = 8'hEF; sN++;
      sExp[sN] = 8'hBE; sN++;
      sRxByte  = 8'hA5;
      sRxValid = 1'b1;
      @(negedge clk);
      sRxValid = 1'b0;
      checkOutput("t5_challenge", 64'(sChallenge), 64'hA5);
      checkOutput("t5_signal_low", 64'(sPufSignal), 64'd0);
      sGot    = 0;
      waitCyc = 0;
      while (sGot < sN && waitCyc < 60) begin
         if (sTxValid) begin
            checkOutput($sformatf("t5_byte%0d", sGot), 64'(sTxByte), 64'(sExp[sGot]));
            sGot++;
         end
         @(negedge clk);
         waitCyc++;
      end
      checkOutput("t5_count", 64'(sGot), 64'(sN));
      checkOutput("t5_done", 64'(sDone), 64'd1);

      // asynchronous reset in the middle of a stalled transmit
      $display("[TB] reset during SEND");
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) applyStimulus(chalA[i]);
      waitCyc = 0;
      while (!tx_valid && waitCyc < 40) begin
         @(negedge clk);
         waitCyc++;
      end
      checkOutput("t1_reached_send", 64'(tx_valid), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("t1_tx_valid", 64'(tx_valid), 64'd0);
      checkOutput("t1_busy", 64'(busy), 64'd0);
      checkOutput("t1_signal", 64'(puf_signal), 64'd1);
      checkOutput("t1_challenge", puf_challenge, 64'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      tx_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("t1_stays_idle", 64'(tx_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
